// File: rtl/cpu_pkg.sv
// Shared definitions for the SAP-style CPU datapath blocks.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; the caller guarantees no push when full without a pop.
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           head,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/input_port_fifo.sv
// CPU input unit: 4-phase req/ack capture from an async source into a FIFO drained onto the W bus.
module input_port_fifo #(
    parameter int unsigned DATA_W      = cpu_pkg::DATA_W,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_req,
    input  logic [DATA_W-1:0] ext_data,
    output logic              ext_ack,
    input  logic              ei_n,
    output logic [DATA_W-1:0] w_bus_out,
    output logic              w_bus_drive,
    output logic              data_ready,
    output logic              underflow
);

    import cpu_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    hs_state_e              state_q, state_d;
    logic                   ack_q, ack_d;
    logic                   underflow_q, underflow_d;

    logic                   req_s;
    logic                   push, pop;
    logic [DATA_W-1:0]      fifo_head;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full, fifo_empty;

    assign req_s      = req_sync_q[SYNC_STAGES-1];
    assign data_ready = (fifo_count != '0);
    assign pop        = ~ei_n & data_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push       = (state_q == HS_IDLE) & req_s & (~fifo_full | pop);

    always_comb begin
        req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], ext_req};
        state_d     = state_q;
        underflow_d = underflow_q | (~ei_n & fifo_empty);
        unique case (state_q)
            HS_IDLE: if (push)   state_d = HS_ACK;
            HS_ACK:  if (!req_s) state_d = HS_IDLE;
            default:             state_d = HS_IDLE;
        endcase
        ack_d = (state_d == HS_ACK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_q  <= '0;
            state_q     <= HS_IDLE;
            ack_q       <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            req_sync_q  <= req_sync_d;
            state_q     <= state_d;
            ack_q       <= ack_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .wdata  (ext_data),
        .head   (fifo_head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign ext_ack     = ack_q;
    assign underflow   = underflow_q;
    assign w_bus_drive = ~ei_n & data_ready;
    assign w_bus_out   = w_bus_drive ? fifo_head : '0;

endmodule
